// File: rtl/controle_cruzamento.sv
// Two-approach traffic light controller (main A, side B) with a pedestrian phase.
// Green is held until an opposing request is pending; every change passes through yellow and all-red.
module controle_cruzamento #(
  parameter int unsigned T_VERDE_MIN = 8,
  parameter int unsigned T_VERDE_MAX = 20,
  parameter int unsigned T_AMARELO   = 3,
  parameter int unsigned T_VERM      = 2,
  parameter int unsigned T_PED       = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       botao,
  output logic [1:0] luz_a,
  output logic [1:0] luz_b,
  output logic       walk,
  output logic [2:0] fase
);

  localparam int unsigned TW = 16;

  localparam logic [TW-1:0] TEMPO_SAT = '1;
  localparam logic [TW-1:0] LIM_MIN   = TW'(T_VERDE_MIN - 1);
  localparam logic [TW-1:0] LIM_MAX   = TW'(T_VERDE_MAX - 1);
  localparam logic [TW-1:0] LIM_AMAR  = TW'(T_AMARELO - 1);
  localparam logic [TW-1:0] LIM_VERM  = TW'(T_VERM - 1);
  localparam logic [TW-1:0] LIM_PED   = TW'(T_PED - 1);

  localparam logic [1:0] LUZ_VERDE   = 2'b00;
  localparam logic [1:0] LUZ_AMARELO = 2'b01;
  localparam logic [1:0] LUZ_VERM    = 2'b10;

  typedef enum logic [2:0] {
    VERDE_A = 3'd0,
    AMAR_A  = 3'd1,
    VERM_AB = 3'd2,
    VERDE_B = 3'd3,
    AMAR_B  = 3'd4,
    VERM_BA = 3'd5,
    PED     = 3'd6
  } estado_t;

  estado_t       state_q, state_d;
  logic [TW-1:0] tempo_q, tempo_d;
  logic          pend_a_q, pend_a_d;
  logic          pend_b_q, pend_b_d;
  logic          pend_ped_q, pend_ped_d;
  logic          ultimo_q, ultimo_d;
  logic [1:0]    luz_a_q, luz_a_d;
  logic [1:0]    luz_b_q, luz_b_d;
  logic          walk_q, walk_d;
  logic [2:0]    fase_q, fase_d;
  logic          entry;

  // Next state, dwell counter, request latches and output decode of the next state
  always_comb begin
    state_d    = state_q;
    tempo_d    = tempo_q;
    pend_a_d   = pend_a_q;
    pend_b_d   = pend_b_q;
    pend_ped_d = pend_ped_q;
    ultimo_d   = ultimo_q;
    luz_a_d    = LUZ_VERM;
    luz_b_d    = LUZ_VERM;
    walk_d     = 1'b0;
    fase_d     = 3'd0;
    entry      = 1'b0;

    case (state_q)
      VERDE_A: begin
        if (tempo_q >= LIM_MIN && (pend_b_q || pend_ped_q) &&
            (!req_a || tempo_q >= LIM_MAX)) begin
          state_d = AMAR_A;
        end
      end
      AMAR_A: begin
        if (tempo_q >= LIM_AMAR) state_d = VERM_AB;
      end
      VERM_AB: begin
        if (tempo_q >= LIM_VERM) state_d = pend_ped_q ? PED : VERDE_B;
      end
      VERDE_B: begin
        if (tempo_q >= LIM_MIN && (pend_a_q || pend_ped_q) &&
            (!req_b || tempo_q >= LIM_MAX)) begin
          state_d = AMAR_B;
        end
      end
      AMAR_B: begin
        if (tempo_q >= LIM_AMAR) state_d = VERM_BA;
      end
      VERM_BA: begin
        if (tempo_q >= LIM_VERM) state_d = pend_ped_q ? PED : VERDE_A;
      end
      PED: begin
        // Prefer the approach that did not have the last green, if it is waiting
        if (tempo_q >= LIM_PED) begin
          if (ultimo_q) state_d = pend_a_q ? VERDE_A : VERDE_B;
          else          state_d = pend_b_q ? VERDE_B : VERDE_A;
        end
      end
      default: state_d = VERDE_A;
    endcase

    entry = (state_d != state_q);

    if (entry)                  tempo_d = '0;
    else if (tempo_q != TEMPO_SAT) tempo_d = tempo_q + TW'(1);

    // Clearing on entry wins over a set in the same cycle
    if (entry && state_d == VERDE_A)  pend_a_d = 1'b0;
    else if (req_a && state_q != VERDE_A) pend_a_d = 1'b1;

    if (entry && state_d == VERDE_B)  pend_b_d = 1'b0;
    else if (req_b && state_q != VERDE_B) pend_b_d = 1'b1;

    if (entry && state_d == PED)      pend_ped_d = 1'b0;
    else if (botao && state_q != PED) pend_ped_d = 1'b1;

    if (entry && state_d == VERDE_A) ultimo_d = 1'b0;
    if (entry && state_d == VERDE_B) ultimo_d = 1'b1;

    case (state_d)
      VERDE_A: luz_a_d = LUZ_VERDE;
      AMAR_A:  luz_a_d = LUZ_AMARELO;
      VERDE_B: luz_b_d = LUZ_VERDE;
      AMAR_B:  luz_b_d = LUZ_AMARELO;
      PED:     walk_d  = 1'b1;
      default: ;
    endcase
    fase_d = state_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= VERDE_A;
      tempo_q    <= '0;
      pend_a_q   <= 1'b0;
      pend_b_q   <= 1'b0;
      pend_ped_q <= 1'b0;
      ultimo_q   <= 1'b0;
      luz_a_q    <= LUZ_VERDE;
      luz_b_q    <= LUZ_VERM;
      walk_q     <= 1'b0;
      fase_q     <= 3'd0;
    end else begin
      state_q    <= state_d;
      tempo_q    <= tempo_d;
      pend_a_q   <= pend_a_d;
      pend_b_q   <= pend_b_d;
      pend_ped_q <= pend_ped_d;
      ultimo_q   <= ultimo_d;
      luz_a_q    <= luz_a_d;
      luz_b_q    <= luz_b_d;
      walk_q     <= walk_d;
      fase_q     <= fase_d;
    end
  end

  assign luz_a = luz_a_q;
  assign luz_b = luz_b_q;
  assign walk  = walk_q;
  assign fase  = fase_q;

endmodule

// File: doc/controle_cruzamento.md
CONTROLE_CRUZAMENTO -- requirements
Module: controle_cruzamento

Interface
REQ-001 The block SHALL have parameter T_VERDE_MIN, default 8: minimum green duration in cycles, at least 1.
REQ-002 The block SHALL have parameter T_VERDE_MAX, default 20: maximum green duration in cycles while an opposing request is pending, at least T_VERDE_MIN.
REQ-003 The block SHALL have parameters T_AMARELO = 3, T_VERM = 2 and T_PED = 6: yellow, all-red clearance and pedestrian phase durations in cycles, each at least 1.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_a, input, 1 bit: vehicle present on approach A (main).
REQ-007 The block SHALL have port req_b, input, 1 bit: vehicle present on approach B (side).
REQ-008 The block SHALL have port botao, input, 1 bit: pedestrian crossing request.
REQ-009 The block SHALL have port luz_a, output, 2 bits: light A, 00 green, 01 yellow, 10 red.
REQ-010 The block SHALL have port luz_b, output, 2 bits: light B, same encoding as luz_a.
REQ-011 The block SHALL have port walk, output, 1 bit: pedestrian walk signal.
REQ-012 The block SHALL have port fase, output, 3 bits: current state code for debug.

Function
REQ-013 States and fase codes SHALL be VERDE_A=0, AMAR_A=1, VERM_AB=2, VERDE_B=3, AMAR_B=4, VERM_BA=5, PED=6.
REQ-014 A 16-bit saturating counter tempo SHALL be 0 on the first cycle of every state and increment by 1 each cycle after that.
REQ-015 Latches pend_a, pend_b and pend_ped SHALL be kept for pending requests.
- pend_a set when req_a=1 and state is not VERDE_A; cleared on the cycle of entry to VERDE_A.
- pend_b set when req_b=1 and state is not VERDE_B; cleared on the cycle of entry to VERDE_B.
- pend_ped set when botao=1 and state is not PED; cleared on the cycle of entry to PED.
- On the entry cycle, clear SHALL win over a simultaneous set.
REQ-016 The block SHALL leave VERDE_A for AMAR_A only when all of these hold:
- tempo >= T_VERDE_MIN-1;
- pend_b or pend_ped is set;
- req_a=0 or tempo >= T_VERDE_MAX-1.
REQ-017 VERDE_B SHALL follow the REQ-016 rule with A and B swapped.
REQ-018 With no opposing request pending, the current green SHALL hold indefinitely.
REQ-019 AMAR_A and AMAR_B SHALL each last exactly T_AMARELO cycles, then go to VERM_AB and VERM_BA respectively.
REQ-020 VERM_AB and VERM_BA SHALL each last exactly T_VERM cycles.
- If pend_ped is set, the next state is PED.
- Otherwise VERM_AB goes to VERDE_B and VERM_BA goes to VERDE_A.
REQ-021 A register ultimo SHALL record the last green approach: 0 for A, 1 for B.
REQ-022 PED SHALL last exactly T_PED cycles, then go to the other approach's green if that approach's pend is set, and otherwise back to green for ultimo.
REQ-023 Outputs SHALL be a pure function of the registered state:
- VERDE_A: luz_a=00, luz_b=10.
- AMAR_A: luz_a=01, luz_b=10.
- VERDE_B: luz_a=10, luz_b=00.
- AMAR_B: luz_a=10, luz_b=01.
- VERM_AB, VERM_BA, PED: both 10.
- walk=1 only in PED.
REQ-024 luz_a and luz_b SHALL never both be non-red in the same cycle.
REQ-025 Every green-to-green change SHALL pass through yellow and then all-red.

Reset
REQ-026 With reset=1 at a rising edge, the next cycle SHALL show the reset state:
- state VERDE_A, tempo=0, ultimo=0;
- pend_a, pend_b, pend_ped all 0;
- luz_a=00, luz_b=10, walk=0, fase=0.
REQ-027 Reset SHALL override every transition and latch set in the same cycle, in any state.

Verification
REQ-028 Idle: reset, then 100 cycles with no inputs -> luz_a=00, luz_b=10 and walk=0 throughout.
REQ-029 Vehicle on B: req_b pulsed 1 cycle, req_a=0 -> sequence below, then B green indefinitely.
- A green for 8 cycles after reset release.
- luz_a=01 for 3 cycles.
- Both lights 10 for 2 cycles.
- luz_b=00 from then on.
REQ-030 Max-out: req_a held 1, req_b pulsed -> A green exactly 20 cycles, then yellow.
REQ-031 Pedestrian only: botao pulsed during VERDE_A -> sequence below, then back to luz_a=00 with pend_ped=0.
- Yellow after tempo 7.
- 2 cycles all-red.
- 6 cycles with walk=1 and both lights 10.
REQ-032 Pedestrian plus vehicle: botao and req_b pending together -> PED is served before VERDE_B; botao pressed during PED is not latched.
REQ-033 Reset mid-operation: reset asserted in AMAR_B with pend_a=1 -> next cycle fase=0, luz_a=00, luz_b=10 and all pends 0.
